// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types and constants for the keycode event unit.
//   ev_type_t   - event type code carried in each FIFO entry (press/release/repeat)
//   kev_state_t - detector state (IDLE, PRESS_PEND)
//   KEY_NONE    - keycode value meaning "no key"
//   pack_event  - builds a 10-bit FIFO entry {type, code}
package keycode_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_REPEAT  = 2'b10
  } ev_type_t;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    PRESS_PEND = 1'b1
  } kev_state_t;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // FIFO entry layout: bits [9:8] event type, bits [7:0] keycode.
  function automatic logic [9:0] pack_event(input ev_type_t t, input logic [7:0] code);
    return {t, code};
  endfunction

endpackage

// File: rtl/keycode_event_fifo.sv
// keycode_event_fifo: synchronous show-ahead FIFO of 10-bit event entries.
// The head entry and its valid flag are registered so that they are stable
// right after the clock edge that changes the FIFO contents.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_data (accepted when not full, or when popping)
//   push_data   - 10-bit entry {type, code}
//   pop         - remove head entry (ignored when empty)
//   full        - DEPTH entries stored
//   head_valid  - FIFO holds at least one entry
//   head_data   - current head entry (zero when empty)
module keycode_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [9:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       head_valid,
  output logic [9:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic          head_valid_q, head_valid_d;
  logic [9:0]    head_q, head_d;
  logic          empty, push_ok, pop_ok;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == CNT_ZERO);
  assign head_valid = head_valid_q;
  assign head_data  = head_q;

  // Next-state for pointers, count, storage and the registered head.
  always_comb begin
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Reading mem_d gives write-through when the new head is written this cycle.
    head_valid_d = (count_d != CNT_ZERO);
    if (head_valid_d) begin
      head_d = mem_d[rd_d];
    end else begin
      head_d = 10'h000;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= CNT_ZERO;
      head_valid_q <= 1'b0;
      head_q       <= 10'h000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: rtl/keycode_event_unit.sv
// keycode_event_unit: turns the sampled USB keycode into a stream of
// press / release (and optionally repeat) events queued in a show-ahead FIFO.
// Optional feature macro: KEYCODE_REPEAT_EN enables auto-repeat events.
// Ports:
//   Clk, Reset      - clock, asynchronous active-high reset
//   keycode         - current keycode, 0x00 = no key
//   ev_valid        - head event present
//   ev_ready        - consumer accepts head event
//   ev_code/ev_type - head event keycode / type (00 press, 01 release, 10 repeat)
//   held_code       - key currently tracked as held
//   overflow        - sticky: a press/release event was dropped
//   clear_overflow  - clears overflow (a new drop in the same cycle wins)
module keycode_event_unit #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic [1:0] ev_type,
  output logic [7:0] held_code,
  output logic       overflow,
  input  logic       clear_overflow
);

  import keycode_pkg::*;

  kev_state_t  state_q, state_d;
  logic [7:0]  kc_q, held_q, held_d;
  logic        ovf_q, ovf_d;
  logic        fsm_push, rep_fire, push, pop, full;
  logic [9:0]  fsm_data, rep_data, push_data, head;

  // Change detector: one event per cycle, a key swap needs two cycles.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    fsm_push = 1'b0;
    fsm_data = 10'h000;
    case (state_q)
      IDLE: begin
        if (kc_q != held_q) begin
          fsm_push = 1'b1;
          held_d   = kc_q;
          if (held_q != KEY_NONE) begin
            fsm_data = pack_event(EV_RELEASE, held_q);
            if (kc_q != KEY_NONE) begin
              state_d = PRESS_PEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            fsm_data = pack_event(EV_PRESS, kc_q);
          end
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_PEND: begin
        // held_q already holds the new key; kc_q is not looked at here.
        fsm_push = 1'b1;
        fsm_data = pack_event(EV_PRESS, held_q);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef KEYCODE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] REP_ONE       = RW'(1);
  localparam logic [RW-1:0] DELAY_LAST    = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST   = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;

  // Repeat timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    rep_data    = pack_event(EV_REPEAT, held_q);
    if ((held_d != held_q) || (held_q == KEY_NONE)) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (!rep_armed_q) begin
      if (rep_cnt_q == DELAY_LAST) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end else begin
      if (rep_cnt_q == PERIOD_LAST) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign rep_fire   = 1'b0;
  assign rep_data   = 10'h000;
`endif

  // Push arbitration (press/release beats repeat) and sticky overflow.
  always_comb begin
    pop  = ev_ready && ev_valid;
    push = fsm_push || rep_fire;
    if (fsm_push) begin
      push_data = fsm_data;
    end else begin
      push_data = rep_data;
    end
    // Only dropped press/release events flag overflow; repeats drop silently.
    if (fsm_push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Input sample, detector state and overflow registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kc_q    <= KEY_NONE;
      held_q  <= KEY_NONE;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      kc_q    <= keycode;
      held_q  <= held_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  keycode_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .head_valid(ev_valid),
    .head_data (head)
  );

  assign ev_code   = head[7:0];
  assign ev_type   = head[9:8];
  assign held_code = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keycode_event_unit.sv
// Directed self-checking bench for keycode_event_unit (FIFO_DEPTH=8,
// REPEAT_DELAY=10, REPEAT_PERIOD=4). Expected values are hand-derived;
// repeat expectations depend on KEYCODE_REPEAT_EN.
module tb_keycode_event_unit;

`ifdef KEYCODE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic [1:0] ev_type;
  logic [7:0] held_code;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;

  keycode_event_unit #(
    .FIFO_DEPTH   (8),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_type       (ev_type),
    .held_code     (held_code),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset          = 1'b1;
    keycode        = 8'h00;
    ev_ready       = 1'b0;
    clear_overflow = 1'b0;
    step();
    step();
    chk("rst_valid", 16'(ev_valid), 16'h0);
    chk("rst_code", 16'(ev_code), 16'h00);
    chk("rst_type", 16'(ev_type), 16'h0);
    chk("rst_held", 16'(held_code), 16'h00);
    chk("rst_ovf", 16'(overflow), 16'h0);
    Reset = 1'b0;
    step();

    // Single press of 0x1A, consumer always ready.
    ev_ready = 1'b1;
    keycode  = 8'h1A;
    step();
    chk("a_valid_e1", 16'(ev_valid), 16'h0);
    step();
    chk("a_valid_e2", 16'(ev_valid), 16'h1);
    chk("a_type", 16'(ev_type), 16'h0);
    chk("a_code", 16'(ev_code), 16'h1A);
    chk("a_held", 16'(held_code), 16'h1A);
    step();
    chk("a_popped", 16'(ev_valid), 16'h0);
    step();
    chk("a_single", 16'(ev_valid), 16'h0);

    // Direct swap 0x1A -> 0x04: release then press on consecutive cycles.
    keycode = 8'h04;
    step();
    chk("b_valid_e1", 16'(ev_valid), 16'h0);
    step();
    chk("b_rel_valid", 16'(ev_valid), 16'h1);
    chk("b_rel_type", 16'(ev_type), 16'h1);
    chk("b_rel_code", 16'(ev_code), 16'h1A);
    chk("b_held", 16'(held_code), 16'h04);
    step();
    chk("b_prs_valid", 16'(ev_valid), 16'h1);
    chk("b_prs_type", 16'(ev_type), 16'h0);
    chk("b_prs_code", 16'(ev_code), 16'h04);
    step();
    chk("b_empty", 16'(ev_valid), 16'h0);

    // Release 0x04 and drain.
    keycode = 8'h00;
    step();
    step();
    chk("c_rel_type", 16'(ev_type), 16'h1);
    step();
    chk("c_drained", 16'(ev_valid), 16'h0);

    // Overflow: nine events with the consumer stalled; eight fit.
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      keycode = (i % 2 == 0) ? 8'h07 : 8'h00;
      step();
      step();
    end
    chk("c_ovf_set", 16'(overflow), 16'h1);
    chk("c_full_valid", 16'(ev_valid), 16'h1);
    chk("c_head_type", 16'(ev_type), 16'h0);
    chk("c_head_code", 16'(ev_code), 16'h07);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("c_ovf_clr", 16'(overflow), 16'h0);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("c_drain%0d_type", i), 16'(ev_type), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk($sformatf("c_drain%0d_code", i), 16'(ev_code), 16'h07);
      step();
    end
    chk("c_drain_empty", 16'(ev_valid), 16'h0);
    keycode = 8'h00;
    step();
    step();
    step();
    step();
    chk("c_final_empty", 16'(ev_valid), 16'h0);
    chk("c_final_held", 16'(held_code), 16'h00);

    // Hold 0x2C: press, then repeats at +10,+14,... only when enabled.
    keycode = 8'h2C;
    step();
    step();
    chk("d_press_valid", 16'(ev_valid), 16'h1);
    chk("d_press_type", 16'(ev_type), 16'h0);
    chk("d_press_code", 16'(ev_code), 16'h2C);
    for (int c = 1; c < 30; c++) begin
      step();
      if (REP_EN && c >= 10 && ((c - 10) % 4 == 0)) begin
        chk($sformatf("d_rep%0d_valid", c), 16'(ev_valid), 16'h1);
        chk($sformatf("d_rep%0d_type", c), 16'(ev_type), 16'h2);
        chk($sformatf("d_rep%0d_code", c), 16'(ev_code), 16'h2C);
      end else begin
        chk($sformatf("d_idle%0d", c), 16'(ev_valid), 16'h0);
      end
    end
    keycode = 8'h00;
    step();
    chk("d_rep30", 16'(ev_valid), 16'(REP_EN));
    step();
    chk("d_rel_valid", 16'(ev_valid), 16'h1);
    chk("d_rel_type", 16'(ev_type), 16'h1);
    chk("d_rel_code", 16'(ev_code), 16'h2C);
    step();
    chk("d_empty", 16'(ev_valid), 16'h0);
    chk("d_ovf", 16'(overflow), 16'h0);

    // Reset mid-operation with three queued events and 0x16 held.
    ev_ready = 1'b0;
    keycode  = 8'h16;
    step();
    step();
    keycode = 8'h00;
    step();
    step();
    keycode = 8'h16;
    step();
    step();
    chk("e_queued_valid", 16'(ev_valid), 16'h1);
    chk("e_held", 16'(held_code), 16'h16);
    Reset = 1'b1;
    #2;
    chk("e_rst_valid", 16'(ev_valid), 16'h0);
    chk("e_rst_held", 16'(held_code), 16'h00);
    chk("e_rst_code", 16'(ev_code), 16'h00);
    step();
    Reset = 1'b0;
    step();
    chk("e_post_e1", 16'(ev_valid), 16'h0);
    step();
    chk("e_press_valid", 16'(ev_valid), 16'h1);
    chk("e_press_type", 16'(ev_type), 16'h0);
    chk("e_press_code", 16'(ev_code), 16'h16);
    ev_ready = 1'b1;
    step();
    chk("e_no_release", 16'(ev_valid), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
